// File: rtl/phys_reg_free_list.sv
// Circular free list of unmapped physical registers: one pop to dispatch, up to two pushes per cycle.
// Optional duplicate-push screening with an in-list bitmap when FREE_LIST_CHECK_EN is defined.
module phys_reg_free_list #(
    parameter int PR_W   = 6,
    parameter int NUM_PR = 64,
    parameter int NUM_AR = 32,
    parameter int DEPTH  = NUM_PR - NUM_AR
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         alloc,
    output logic                         alloc_ok,
    output logic [PR_W-1:0]              PR_new_DP,
    output logic                         empty,
    input  logic                         retire_reg,
    input  logic [PR_W-1:0]              PR_old_RT,
    input  logic                         recover,
    input  logic [PR_W-1:0]              PR_new_flush,
    output logic [$clog2(DEPTH+1)-1:0]   free_cnt,
    output logic                         ovf_err,
    output logic                         dup_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [PR_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] tail_c;
    logic             r_ok;
    logic             c_ok;
    logic             r_acc;
    logic             c_acc;
    logic             ovf;
    logic [1:0]       push_n;
    logic [CNT_W:0]   room;

    assign empty     = (free_cnt == '0);
    assign alloc_ok  = alloc & ~empty;
    assign PR_new_DP = mem[head];

`ifdef FREE_LIST_CHECK_EN
    logic [NUM_PR-1:0] in_list;
    logic              r_dup;
    logic              c_dup;

    // Retire is first in push order, so a recover matching it is the one treated as the duplicate.
    assign r_dup = retire_reg & in_list[PR_old_RT];
    assign c_dup = recover & (in_list[PR_new_flush] | (retire_reg & (PR_new_flush == PR_old_RT)));
    assign r_ok  = retire_reg & ~r_dup;
    assign c_ok  = recover & ~c_dup;

    always_ff @(posedge clk) begin
        if (!rst) begin
            in_list <= {{(NUM_PR-NUM_AR){1'b1}}, {NUM_AR{1'b0}}};
            dup_err <= 1'b0;
        end else begin
            if (alloc_ok) in_list[PR_new_DP] <= 1'b0;
            if (r_acc)    in_list[PR_old_RT] <= 1'b1;
            if (c_acc)    in_list[PR_new_flush] <= 1'b1;
            if (r_dup | c_dup) dup_err <= 1'b1;
        end
    end
`else
    assign r_ok    = retire_reg;
    assign c_ok    = recover;
    assign dup_err = 1'b0;
`endif

    // Free slots this cycle, counting the slot released by a same-cycle pop; recover loses first.
    assign room   = (CNT_W+1)'(DEPTH) - {1'b0, free_cnt} + {{CNT_W{1'b0}}, alloc_ok};
    assign r_acc  = r_ok & (room != '0);
    assign c_acc  = c_ok & (room > {{CNT_W{1'b0}}, r_acc});
    assign ovf    = (r_ok & ~r_acc) | (c_ok & ~c_acc);
    assign push_n = {1'b0, r_acc} + {1'b0, c_acc};
    assign tail_c = r_acc ? tail + 1'b1 : tail;

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= PR_W'(NUM_AR + i);
            end
            head     <= '0;
            tail     <= '0;
            free_cnt <= CNT_W'(DEPTH);
            ovf_err  <= 1'b0;
        end else begin
            if (r_acc) mem[tail]   <= PR_old_RT;
            if (c_acc) mem[tail_c] <= PR_new_flush;
            if (alloc_ok) head <= head + 1'b1;
            tail     <= tail + PTR_W'(push_n);
            free_cnt <= free_cnt + CNT_W'(push_n) - CNT_W'(alloc_ok);
            if (ovf) ovf_err <= 1'b1;
        end
    end

endmodule
